// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared micro-op types for the decode stage
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_SHL  = 4'h6,
        OP_SHR  = 4'h7,
        OP_LD   = 4'h8,
        OP_ST   = 4'h9,
        OP_BEQZ = 4'hA,
        OP_RSVB = 4'hB,
        OP_RSVC = 4'hC,
        OP_RSVD = 4'hD,
        OP_RSVE = 4'hE,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        CLS_ALU = 2'd0,
        CLS_MEM = 2'd1,
        CLS_BR  = 2'd2,
        CLS_SYS = 2'd3
    } uop_class_e;

    typedef struct packed {
        opcode_e    op;
        logic [1:0] rd;
        logic [1:0] rs;
        uop_class_e cls;
        logic       wr_rd;
        logic       illegal;
        logic [7:0] pc;
    } uop_t;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational 8-bit instruction to micro-op field decode
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [7:0] instr,
    output opcode_e    op,
    output logic [1:0] rd,
    output logic [1:0] rs,
    output uop_class_e cls,
    output logic       wr_rd,
    output logic       illegal
);

    assign op = opcode_e'(instr[7:4]);
    assign rd = instr[3:2];
    assign rs = instr[1:0];

    always_comb begin
        cls     = CLS_SYS;
        wr_rd   = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_NOP:                          cls = CLS_ALU;
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SHL, OP_SHR: begin
                cls   = CLS_ALU;
                wr_rd = 1'b1;
            end
            OP_LD: begin
                cls   = CLS_MEM;
                wr_rd = 1'b1;
            end
            OP_ST:                           cls = CLS_MEM;
            OP_BEQZ:                         cls = CLS_BR;
            OP_HALT:                         cls = CLS_SYS;
            default:                         illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - decode stage with in-order micro-op FIFO and flush
module decode_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [7:0]    in_instr,
    input  logic [7:0]    in_pc,
    output logic          in_ready,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_op,
    output logic [1:0]    out_rd,
    output logic [1:0]    out_rs,
    output logic [1:0]    out_class,
    output logic          out_wr_rd,
    output logic          out_illegal,
    output logic [7:0]    out_pc,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    uop_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          enq;
    logic          deq;
    uop_t          head;

    opcode_e       dec_op;
    logic [1:0]    dec_rd;
    logic [1:0]    dec_rs;
    uop_class_e    dec_cls;
    logic          dec_wr_rd;
    logic          dec_illegal;

    instr_decoder u_dec (
        .instr   (in_instr),
        .op      (dec_op),
        .rd      (dec_rd),
        .rs      (dec_rs),
        .cls     (dec_cls),
        .wr_rd   (dec_wr_rd),
        .illegal (dec_illegal)
    );

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign enq       = in_valid && in_ready && !flush;
    assign deq       = out_valid && out_ready && !flush;

    // Storage carries no reset; validity is tracked purely by pointers and count.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= '{op: dec_op, rd: dec_rd, rs: dec_rs, cls: dec_cls,
                             wr_rd: dec_wr_rd, illegal: dec_illegal, pc: in_pc};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head        = mem[rd_ptr];
    assign out_op      = head.op;
    assign out_rd      = head.rd;
    assign out_rs      = head.rs;
    assign out_class   = head.cls;
    assign out_wr_rd   = head.wr_rd;
    assign out_illegal = head.illegal;
    assign out_pc      = head.pc;

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - self-checking bench for decode_queue
module tb_decode_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_instr = '0;
    logic [7:0]    in_pc = '0;
    logic          in_ready;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [3:0]    out_op;
    logic [1:0]    out_rd;
    logic [1:0]    out_rs;
    logic [1:0]    out_class;
    logic          out_wr_rd;
    logic          out_illegal;
    logic [7:0]    out_pc;
    logic [CW-1:0] count;

    decode_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_ready    (in_ready),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_rd      (out_rd),
        .out_rs      (out_rs),
        .out_class   (out_class),
        .out_wr_rd   (out_wr_rd),
        .out_illegal (out_illegal),
        .out_pc      (out_pc),
        .count       (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] instr;
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [1:0] cls;
        logic       wr;
        logic       ill;
    } vec_t;

    vec_t        vt [16];
    logic [15:0] model_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the opcode-range rules.
    task automatic check_model();
        logic [3:0] opc;
        int cls;
        chk("count", int'(count), model_q.size());
        chk("in_ready", int'(in_ready), int'(model_q.size() != DEPTH));
        chk("out_valid", int'(out_valid), int'(model_q.size() != 0));
        if (model_q.size() != 0) begin
            opc = model_q[0][15:12];
            if (opc < 8) cls = 0;
            else if (opc < 10) cls = 1;
            else if (opc == 10) cls = 2;
            else cls = 3;
            chk("op", int'(out_op), int'(opc));
            chk("rd", int'(out_rd), int'(model_q[0][11:10]));
            chk("rs", int'(out_rs), int'(model_q[0][9:8]));
            chk("class", int'(out_class), cls);
            chk("wr_rd", int'(out_wr_rd), int'(opc >= 1 && opc <= 8));
            chk("illegal", int'(out_illegal), int'(opc >= 11 && opc <= 14));
            chk("pc", int'(out_pc), int'(model_q[0][7:0]));
        end
    endtask

    // One clock: drive at negedge, check against model, advance model at posedge, then idle inputs.
    task automatic cycle(input logic v, input logic [7:0] ins, input logic [7:0] pc,
                         input logic ordy, input logic fl, output logic acc);
        logic deq;
        @(negedge clk);
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
        #1;
        check_model();
        acc = v && (model_q.size() != DEPTH) && !fl;
        deq = ordy && (model_q.size() != 0) && !fl;
        @(posedge clk);
        if (fl) model_q.delete();
        else begin
            if (deq) void'(model_q.pop_front());
            if (acc) model_q.push_back({ins, pc});
        end
        #1;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc;
        logic [7:0] pc;
        int tries;

        vt[0]  = '{8'h0B, 4'h0, 2'd2, 2'd3, 2'd0, 1'b0, 1'b0};
        vt[1]  = '{8'h17, 4'h1, 2'd1, 2'd3, 2'd0, 1'b1, 1'b0};
        vt[2]  = '{8'h26, 4'h2, 2'd1, 2'd2, 2'd0, 1'b1, 1'b0};
        vt[3]  = '{8'h31, 4'h3, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0};
        vt[4]  = '{8'h4C, 4'h4, 2'd3, 2'd0, 2'd0, 1'b1, 1'b0};
        vt[5]  = '{8'h5E, 4'h5, 2'd3, 2'd2, 2'd0, 1'b1, 1'b0};
        vt[6]  = '{8'h65, 4'h6, 2'd1, 2'd1, 2'd0, 1'b1, 1'b0};
        vt[7]  = '{8'h7F, 4'h7, 2'd3, 2'd3, 2'd0, 1'b1, 1'b0};
        vt[8]  = '{8'h80, 4'h8, 2'd0, 2'd0, 2'd1, 1'b1, 1'b0};
        vt[9]  = '{8'h94, 4'h9, 2'd1, 2'd0, 2'd1, 1'b0, 1'b0};
        vt[10] = '{8'hA3, 4'hA, 2'd0, 2'd3, 2'd2, 1'b0, 1'b0};
        vt[11] = '{8'hB1, 4'hB, 2'd0, 2'd1, 2'd3, 1'b0, 1'b1};
        vt[12] = '{8'hC5, 4'hC, 2'd1, 2'd1, 2'd3, 1'b0, 1'b1};
        vt[13] = '{8'hD2, 4'hD, 2'd0, 2'd2, 2'd3, 1'b0, 1'b1};
        vt[14] = '{8'hEA, 4'hE, 2'd2, 2'd2, 2'd3, 1'b0, 1'b1};
        vt[15] = '{8'hF0, 4'hF, 2'd0, 2'd0, 2'd3, 1'b0, 1'b0};

        // Reset state
        #12;
        chk("rst_count", int'(count), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(negedge clk); rst_n = 1'b1;

        // First instruction: 0x16 @ 0x05 visible the next cycle
        cycle(1'b1, 8'h16, 8'h05, 1'b0, 1'b0, acc);
        chk("add_valid", int'(out_valid), 1);
        chk("add_op", int'(out_op), 1);
        chk("add_rd", int'(out_rd), 1);
        chk("add_rs", int'(out_rs), 2);
        chk("add_class", int'(out_class), 0);
        chk("add_wr", int'(out_wr_rd), 1);
        chk("add_ill", int'(out_illegal), 0);
        chk("add_pc", int'(out_pc), 5);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);

        // Decode table, one instruction at a time
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, vt[i].instr, 8'(8'h40 + i), 1'b0, 1'b0, acc);
            chk("tbl_valid", int'(out_valid), 1);
            chk("tbl_op", int'(out_op), int'(vt[i].op));
            chk("tbl_rd", int'(out_rd), int'(vt[i].rd));
            chk("tbl_rs", int'(out_rs), int'(vt[i].rs));
            chk("tbl_class", int'(out_class), int'(vt[i].cls));
            chk("tbl_wr", int'(out_wr_rd), int'(vt[i].wr));
            chk("tbl_ill", int'(out_illegal), int'(vt[i].ill));
            chk("tbl_pc", int'(out_pc), 8'h40 + i);
            cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
        end

        // Fill to full, fifth instruction held until space frees
        cycle(1'b1, 8'h80, 8'h10, 1'b0, 1'b0, acc);
        cycle(1'b1, 8'h94, 8'h11, 1'b0, 1'b0, acc);
        cycle(1'b1, 8'hA3, 8'h12, 1'b0, 1'b0, acc);
        cycle(1'b1, 8'hF0, 8'h13, 1'b0, 1'b0, acc);
        chk("full_count", int'(count), 4);
        chk("full_in_ready", int'(in_ready), 0);
        cycle(1'b1, 8'h26, 8'h14, 1'b0, 1'b0, acc);
        chk("full_no_accept", int'(acc), 0);
        cycle(1'b1, 8'h26, 8'h14, 1'b1, 1'b0, acc);
        chk("full_no_passthru", int'(acc), 0);
        chk("full_in_ready_rise", int'(in_ready), 1);
        tries = 0;
        do begin
            cycle(1'b1, 8'h26, 8'h14, 1'b1, 1'b0, acc);
            tries++;
        end while (!acc && tries < 8);
        chk("fifth_accepted", int'(acc), 1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
        chk("drain_count", int'(count), 0);

        // Streaming: 10 instructions with continuous handshakes, pointers wrap
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'(8'h11 * i), 8'(8'h20 + i), 1'b1, 1'b0, acc);
            chk("stream_count", int'(count), 1);
            chk("stream_pc", int'(out_pc), 8'h20 + i);
        end
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);

        // Flush on a full queue with both handshakes presented
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h31, 8'(8'h50 + i), 1'b0, 1'b0, acc);
        cycle(1'b1, 8'h7F, 8'h60, 1'b1, 1'b1, acc);
        chk("flush_count", int'(count), 0);
        chk("flush_out_valid", int'(out_valid), 0);
        chk("flush_in_ready", int'(in_ready), 1);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);

        // Asynchronous reset between edges with three entries queued
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h65, 8'(8'h70 + i), 1'b0, 1'b0, acc);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_out_valid", int'(out_valid), 0);
        model_q.delete();
        @(negedge clk); rst_n = 1'b1;
        cycle(1'b1, 8'h21, 8'h9C, 1'b0, 1'b0, acc);
        chk("post_rst_op", int'(out_op), 2);
        chk("post_rst_pc", int'(out_pc), 8'h9C);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);

        // Randomized traffic against the queue model
        pc = 8'h00;
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), pc,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0), acc);
            if (acc) pc = pc + 8'd1;
        end
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
